// File: rtl/dda_column_rasterizer.sv
// Column rasterizer: turns one DDA-out record into a 240-row column of ceiling/wall/floor
// pixels, writing one pixel per clock into the back buffer and swapping buffers on tlast.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | tready high, waiting for a record
// LOAD  | wall span derived from latched record; drop or start drawing
// DRAW  | one framebuffer write per clock, row 0 .. SCREEN_HEIGHT-1
// FLIP  | swap front/back buffer, pulse frame_done
module dda_column_rasterizer #(
    parameter int         SCREEN_WIDTH  = 320,
    parameter int         SCREEN_HEIGHT = 240,
    parameter logic [7:0] CEIL_COLOR    = 8'h01,
    parameter logic [7:0] FLOOR_COLOR   = 8'h02
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        fifo_tvalid_in,
    input  logic [38:0] fifo_tdata_in,
    input  logic        fifo_tlast_in,
    output logic        fifo_tready_out,
    output logic [16:0] fb_addr_out,
    output logic [7:0]  fb_data_out,
    output logic        fb_we_out,
    output logic        fb_buf_out,
    output logic        display_buf_out,
    output logic        frame_done_out,
    output logic        drop_err_out
);

    localparam logic [8:0]  WIDTH_C  = 9'(SCREEN_WIDTH);
    localparam logic [16:0] WIDTH_A  = 17'(SCREEN_WIDTH);
    localparam logic [8:0]  HEIGHT_C = 9'(SCREEN_HEIGHT);
    localparam logic [7:0]  ROW_LAST = 8'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_FLIP = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [8:0]  hcount_q;
    logic [7:0]  lh_q;
    logic [3:0]  wall_q;
    logic        side_q;
    logic        tlast_q;

    logic        tready_q, tready_d;
    logic        we_q, we_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  row_q, row_d;
    logic        buf_q, buf_d;
    logic        done_q, done_d;
    logic        drop_q, drop_d;

    logic        accept_c;
    logic        drop_c;
    logic [8:0]  lh_c;
    logic [8:0]  start_c;
    logic [8:0]  end_c;

    logic        unused_reserved;
    assign unused_reserved = ^fifo_tdata_in[16:0];

    assign accept_c = fifo_tvalid_in && tready_q && (state_q == S_IDLE);
    assign drop_c   = (hcount_q >= WIDTH_C);

    // Wall span is constant for the whole column, so it is derived straight from the latched record.
    always_comb begin
        lh_c    = ({1'b0, lh_q} > HEIGHT_C) ? HEIGHT_C : {1'b0, lh_q};
        start_c = (HEIGHT_C - lh_c) >> 1;
        end_c   = start_c + lh_c;
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (drop_c) begin
                    state_d = tlast_q ? S_FLIP : S_IDLE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (row_q == ROW_LAST) begin
                    state_d = tlast_q ? S_FLIP : S_IDLE;
                end
            end
            S_FLIP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values for the registered outputs, computed from the transition being taken.
    always_comb begin
        tready_d = (state_d == S_IDLE);
        we_d     = (state_d == S_DRAW);
        row_d    = row_q;
        addr_d   = addr_q;
        data_d   = data_q;
        buf_d    = buf_q;
        done_d   = 1'b0;
        drop_d   = drop_q;

        if (state_q == S_LOAD && state_d == S_DRAW) begin
            row_d  = 8'd0;
            addr_d = {8'd0, hcount_q};
        end else if (state_q == S_DRAW && state_d == S_DRAW) begin
            row_d  = 8'(row_q + 8'd1);
            addr_d = addr_q + WIDTH_A;
        end

        if (state_d == S_DRAW) begin
            if ({1'b0, row_d} < start_c) begin
                data_d = CEIL_COLOR;
            end else if ({1'b0, row_d} < end_c) begin
                data_d = {3'b100, side_q, wall_q};
            end else begin
                data_d = FLOOR_COLOR;
            end
        end

        if (state_q == S_LOAD && drop_c) begin
            drop_d = 1'b1;
        end

        if (state_q == S_FLIP) begin
            buf_d  = ~buf_q;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            tready_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            row_q    <= '0;
            buf_q    <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            tready_q <= tready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            row_q    <= row_d;
            buf_q    <= buf_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            hcount_q <= '0;
            lh_q     <= '0;
            wall_q   <= '0;
            side_q   <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (accept_c) begin
            hcount_q <= fifo_tdata_in[38:30];
            lh_q     <= fifo_tdata_in[29:22];
            wall_q   <= fifo_tdata_in[21:18];
            side_q   <= fifo_tdata_in[17];
            tlast_q  <= fifo_tlast_in;
        end
    end

    assign fifo_tready_out = tready_q;
    assign fb_we_out       = we_q;
    assign fb_addr_out     = addr_q;
    assign fb_data_out     = data_q;
    assign fb_buf_out      = buf_q;
    assign display_buf_out = ~buf_q;
    assign frame_done_out  = done_q;
    assign drop_err_out    = drop_q;

endmodule

// File: tb/tb_dda_column_rasterizer.sv
// Directed bench for dda_column_rasterizer: hand-computed wall spans, write timing,
// buffer swaps, dropped records and reset in the middle of a column.
module tb_dda_column_rasterizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_tvalid_in = 1'b0;
    logic [38:0] fifo_tdata_in = '0;
    logic        fifo_tlast_in = 1'b0;
    logic        fifo_tready_out;
    logic [16:0] fb_addr_out;
    logic [7:0]  fb_data_out;
    logic        fb_we_out;
    logic        fb_buf_out;
    logic        display_buf_out;
    logic        frame_done_out;
    logic        drop_err_out;

    int checks = 0;
    int errors = 0;

    dda_column_rasterizer dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst),
        .fifo_tvalid_in  (fifo_tvalid_in),
        .fifo_tdata_in   (fifo_tdata_in),
        .fifo_tlast_in   (fifo_tlast_in),
        .fifo_tready_out (fifo_tready_out),
        .fb_addr_out     (fb_addr_out),
        .fb_data_out     (fb_data_out),
        .fb_we_out       (fb_we_out),
        .fb_buf_out      (fb_buf_out),
        .display_buf_out (display_buf_out),
        .frame_done_out  (frame_done_out),
        .drop_err_out    (drop_err_out)
    );

    always #5 clk = ~clk;

    // Edge log: what the framebuffer and FIFO would see at each rising edge.
    int   cyc = 0;
    int   wq_addr[$];
    int   wq_data[$];
    int   wq_cyc[$];
    int   acc_q[$];
    int   rise_q[$];
    int   fd_cyc[$];
    int   fd_buf[$];
    logic prev_rdy = 1'b0;

    always @(posedge clk) begin
        if (fb_we_out === 1'b1) begin
            wq_addr.push_back(int'(fb_addr_out));
            wq_data.push_back(int'(fb_data_out));
            wq_cyc.push_back(cyc);
        end
        if (fifo_tvalid_in && fifo_tready_out === 1'b1) acc_q.push_back(cyc);
        if (fifo_tready_out === 1'b1 && !prev_rdy) rise_q.push_back(cyc);
        if (frame_done_out === 1'b1) begin
            fd_cyc.push_back(cyc);
            fd_buf.push_back(int'(fb_buf_out));
        end
        prev_rdy = (fifo_tready_out === 1'b1);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [8:0] hc, input logic [7:0] lh, input logic [3:0] wt,
                        input logic side, input logic last, input logic keep, output int acc);
        int n;
        n = acc_q.size();
        fifo_tdata_in  = {hc, lh, wt, side, 17'h1ABCD};
        fifo_tlast_in  = last;
        fifo_tvalid_in = 1'b1;
        for (int i = 0; i < 1000 && acc_q.size() == n; i++) begin
            @(posedge clk);
            #1;
        end
        if (acc_q.size() == n) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed=%0d expected=%0d", 0, 1);
            acc = -100000;
        end else begin
            acc = acc_q[n];
        end
        if (!keep) begin
            fifo_tvalid_in = 1'b0;
            fifo_tdata_in  = '1;
            fifo_tlast_in  = ~last;
        end
    endtask

    task automatic check_col(input string tag, input int idx0, input int acc, input int hc,
                             input int st, input int en, input logic [7:0] wc);
        logic [7:0] exp_pix;
        if (idx0 + 239 < wq_cyc.size()) begin
            chk({tag, "_first_cyc"}, wq_cyc[idx0], acc + 2);
            chk({tag, "_last_cyc"}, wq_cyc[idx0 + 239], acc + 241);
        end
        for (int r = 0; r < 240; r++) begin
            if (idx0 + r < wq_addr.size()) begin
                exp_pix = (r < st) ? 8'h01 : (r < en) ? wc : 8'h02;
                chk($sformatf("%s_addr_r%0d", tag, r), wq_addr[idx0 + r], r * 320 + hc);
                chk($sformatf("%s_data_r%0d", tag, r), wq_data[idx0 + r], {24'd0, exp_pix});
            end
        end
    endtask

    initial begin
        int acc;
        int acc2;
        int idx;
        int ok;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", fifo_tready_out, 0);
        chk("rst_we", fb_we_out, 0);
        chk("rst_addr", fb_addr_out, 0);
        chk("rst_data", fb_data_out, 0);
        chk("rst_buf", fb_buf_out, 0);
        chk("rst_display", display_buf_out, 1);
        chk("rst_frame_done", frame_done_out, 0);
        chk("rst_drop", drop_err_out, 0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_release", fifo_tready_out, 1);

        // No valid: idle, no writes
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_writes", wq_addr.size(), 0);
        chk("idle_tready", fifo_tready_out, 1);
        chk("idle_no_accept", acc_q.size(), 0);

        // hcount=5, lh=100, wall 3, side 1
        idx = wq_addr.size();
        send(9'd5, 8'd100, 4'd3, 1'b1, 1'b0, 1'b0, acc);
        repeat (250) @(posedge clk);
        #1;
        chk("colA_count", wq_addr.size(), idx + 240);
        check_col("colA", idx, acc, 5, 70, 170, 8'h93);
        chk("colA_tready_rise", rise_q[$], acc + 242);
        chk("colA_no_frame_done", fd_cyc.size(), 0);

        // lh=0: ceiling / floor only
        idx = wq_addr.size();
        send(9'd0, 8'd0, 4'd7, 1'b0, 1'b0, 1'b0, acc);
        repeat (250) @(posedge clk);
        #1;
        chk("lh0_count", wq_addr.size(), idx + 240);
        check_col("lh0", idx, acc, 0, 120, 120, 8'h87);

        // lh=255: all wall
        idx = wq_addr.size();
        send(9'd10, 8'd255, 4'hA, 1'b0, 1'b0, 1'b0, acc);
        repeat (250) @(posedge clk);
        #1;
        chk("lh255_count", wq_addr.size(), idx + 240);
        check_col("lh255", idx, acc, 10, 0, 240, 8'h8A);

        // Back-to-back with tvalid held high
        idx = wq_addr.size();
        send(9'd100, 8'd50, 4'd1, 1'b0, 1'b0, 1'b1, acc);
        send(9'd101, 8'd241, 4'd2, 1'b1, 1'b0, 1'b0, acc2);
        chk("b2b_spacing", acc2 - acc, 242);
        repeat (250) @(posedge clk);
        #1;
        chk("b2b_count", wq_addr.size(), idx + 480);
        check_col("b2b1", idx, acc, 100, 95, 145, 8'h81);
        check_col("b2b2", idx + 240, acc2, 101, 0, 240, 8'h92);
        chk("b2b_accepts", acc_q.size(), 5);

        // Last column of a frame
        chk("pre_flip_buf", fb_buf_out, 0);
        idx = wq_addr.size();
        send(9'd319, 8'd120, 4'd5, 1'b0, 1'b1, 1'b0, acc);
        repeat (250) @(posedge clk);
        #1;
        chk("flip_count", wq_addr.size(), idx + 240);
        check_col("flip", idx, acc, 319, 60, 180, 8'h85);
        chk("flip_pulses", fd_cyc.size(), 1);
        chk("flip_pulse_cyc", fd_cyc[$], acc + 243);
        chk("flip_pulse_buf", fd_buf[$], 1);
        chk("flip_buf", fb_buf_out, 1);
        chk("flip_display", display_buf_out, 0);
        chk("flip_tready_rise", rise_q[$], acc + 243);

        // Reset at DRAW row 50
        idx = wq_addr.size();
        send(9'd7, 8'd100, 4'd3, 1'b1, 1'b0, 1'b0, acc);
        ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            @(posedge clk);
            #1;
            if (wq_addr.size() >= idx + 51) ok = 1;
        end
        chk("midrst_reached_row50", ok, 1);
        rst = 1'b1;
        #1;
        chk("midrst_we", fb_we_out, 0);
        chk("midrst_tready", fifo_tready_out, 0);
        chk("midrst_buf", fb_buf_out, 0);
        chk("midrst_display", display_buf_out, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_partial_writes", wq_addr.size(), idx + 51);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idx = wq_addr.size();
        send(9'd8, 8'd20, 4'd4, 1'b1, 1'b0, 1'b0, acc);
        repeat (250) @(posedge clk);
        #1;
        chk("postrst_count", wq_addr.size(), idx + 240);
        check_col("postrst", idx, acc, 8, 110, 130, 8'h94);
        chk("postrst_buf", fb_buf_out, 0);
        chk("postrst_drop", drop_err_out, 0);

        // Dropped record with tlast still flips
        idx = wq_addr.size();
        send(9'd400, 8'd100, 4'd3, 1'b1, 1'b1, 1'b0, acc);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_no_writes", wq_addr.size(), idx);
        chk("drop_err", drop_err_out, 1);
        chk("drop_pulses", fd_cyc.size(), 2);
        chk("drop_pulse_cyc", fd_cyc[$], acc + 3);
        chk("drop_tready_rise", rise_q[$], acc + 3);
        chk("drop_buf", fb_buf_out, 1);
        chk("drop_display", display_buf_out, 0);

        // Sticky error survives a normal column
        idx = wq_addr.size();
        send(9'd200, 8'd240, 4'hF, 1'b1, 1'b0, 1'b0, acc);
        repeat (250) @(posedge clk);
        #1;
        chk("after_drop_count", wq_addr.size(), idx + 240);
        check_col("after_drop", idx, acc, 200, 0, 240, 8'h9F);
        chk("drop_sticky", drop_err_out, 1);
        chk("after_drop_buf", fb_buf_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
